// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one multi-cycle calculator between two requesters.
// Optional per-requester grant and error counters are enabled by defining CALC_ARB_STATS_EN.
module calc_arbiter #(
    parameter int CALC_LAT = 2,
    parameter int MAX_OP   = 5
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [7:0]  r0_opcode,
    input  logic [15:0] r0_a,
    input  logic [15:0] r0_b,
    input  logic [15:0] r0_c,
    input  logic [15:0] r0_d,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [7:0]  r1_opcode,
    input  logic [15:0] r1_a,
    input  logic [15:0] r1_b,
    input  logic [15:0] r1_c,
    input  logic [15:0] r1_d,

    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,

    output logic [15:0] calc_a,
    output logic [15:0] calc_b,
    output logic [15:0] calc_c,
    output logic [15:0] calc_d,
    output logic [7:0]  calc_opcode,
    input  logic [15:0] calc_out,

    output logic        busy
`ifdef CALC_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(CALC_LAT - 1);

    state_t      r_state;
    logic        r_last_grant;
    logic        r_gnt_id;
    logic [3:0]  r_cnt;
    logic [15:0] r_calc_a;
    logic [15:0] r_calc_b;
    logic [15:0] r_calc_c;
    logic [15:0] r_calc_d;
    logic [7:0]  r_calc_opcode;
    logic [15:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_sel;
    logic        w_accept;
    logic        w_illegal;
    logic        w_rsp_take;
    logic [7:0]  w_opcode;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_c;
    logic [15:0] w_d;

    always_comb begin
        // NOTE: assign a default before any branch so the selector can never infer a latch.
        w_sel = 1'b0;
        if (r0_valid && r1_valid)
            w_sel = ~r_last_grant;
        else if (r1_valid)
            w_sel = 1'b1;
    end

    assign w_accept   = (r_state == IDLE) && (r0_valid || r1_valid);
    assign r0_ready   = w_accept && !w_sel;
    assign r1_ready   = w_accept &&  w_sel;

    assign w_opcode   = w_sel ? r1_opcode : r0_opcode;
    assign w_a        = w_sel ? r1_a : r0_a;
    assign w_b        = w_sel ? r1_b : r0_b;
    assign w_c        = w_sel ? r1_c : r0_c;
    assign w_d        = w_sel ? r1_d : r0_d;
    assign w_illegal  = w_opcode > 8'(MAX_OP);
    assign w_rsp_take = r_gnt_id ? r1_rsp_ready : r0_rsp_ready;

    // Rejected opcodes skip WAIT and leave the calculator inputs untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_grant  <= 1'b1;
            r_gnt_id      <= 1'b0;
            r_cnt         <= '0;
            r_calc_a      <= '0;
            r_calc_b      <= '0;
            r_calc_c      <= '0;
            r_calc_d      <= '0;
            r_calc_opcode <= '0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_sel;
                        r_gnt_id     <= w_sel;
                        if (w_illegal) begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= '0;
                            r_state    <= RESP;
                        end else begin
                            r_calc_a      <= w_a;
                            r_calc_b      <= w_b;
                            r_calc_c      <= w_c;
                            r_calc_d      <= w_d;
                            r_calc_opcode <= w_opcode;
                            r_cnt         <= CNT_LOAD;
                            r_state       <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_data <= calc_out;
                        r_rsp_err  <= 1'b0;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (w_rsp_take)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CALC_ARB_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;
    logic [7:0]  r_err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_err_cnt    <= '0;
        end else if (w_accept) begin
            if (!w_sel && r_grant_cnt0 != '1)
                r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
            if (w_sel && r_grant_cnt1 != '1)
                r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
            if (w_illegal && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign err_cnt    = r_err_cnt;
`endif

    assign r0_rsp_valid = (r_state == RESP) && !r_gnt_id;
    assign r1_rsp_valid = (r_state == RESP) &&  r_gnt_id;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign calc_a       = r_calc_a;
    assign calc_b       = r_calc_b;
    assign calc_c       = r_calc_c;
    assign calc_d       = r_calc_d;
    assign calc_opcode  = r_calc_opcode;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with a one-register calculator model (CALC_LAT = 2).
module tb_calc_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [7:0]  r0_opcode, r1_opcode;
    logic [15:0] r0_a, r0_b, r0_c, r0_d, r1_a, r1_b, r1_c, r1_d;
    logic        r0_rsp_valid, r0_rsp_ready, r1_rsp_valid, r1_rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] calc_a, calc_b, calc_c, calc_d, calc_out;
    logic [7:0]  calc_opcode;
    logic        busy;
`ifdef CALC_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
    logic [7:0]  err_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    calc_arbiter #(.CALC_LAT(2), .MAX_OP(5)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode),
        .r0_a(r0_a), .r0_b(r0_b), .r0_c(r0_c), .r0_d(r0_d),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode),
        .r1_a(r1_a), .r1_b(r1_b), .r1_c(r1_c), .r1_d(r1_d),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .calc_a(calc_a), .calc_b(calc_b), .calc_c(calc_c), .calc_d(calc_d),
        .calc_opcode(calc_opcode), .calc_out(calc_out),
        .busy(busy)
`ifdef CALC_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt)
`endif
    );

    function automatic logic [15:0] calc_fn(input logic [7:0] op, input logic [15:0] a, b, c, d);
        case (op)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd2:    return a * b;
            8'd3:    return (b == 16'd0) ? 16'd0 : a / b;
            8'd4:    return a + b + c + d;
            8'd5:    return a ^ b;
            default: return 16'd0;
        endcase
    endfunction

    // One register stage: the result is valid one cycle after the inputs settle.
    always @(posedge clk)
        calc_out <= calc_fn(calc_opcode, calc_a, calc_b, calc_c, calc_d);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        if (id == 0) begin
            r0_valid = 1'b1; r0_opcode = op; r0_a = a; r0_b = b;
        end else begin
            r1_valid = 1'b1; r1_opcode = op; r1_a = a; r1_b = b;
        end
    endtask

    function automatic logic rsp_v(input int id);
        return (id == 0) ? r0_rsp_valid : r1_rsp_valid;
    endfunction

    // Counts cycles after the accept edge until the response shows up.
    task automatic wait_rsp(input string tag, input int id, input int exp_lat,
                            input logic [15:0] exp_data, input logic exp_err);
        int n = 0;
        while (!rsp_v(id) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, rsp_err, exp_err);
        check({tag, "_other_v"}, rsp_v(1 - id), 1'b0);
    endtask

    task automatic take_rsp(input string tag, input int id);
        if (id == 0) r0_rsp_ready = 1'b1; else r1_rsp_ready = 1'b1;
        tick();
        r0_rsp_ready = 1'b0;
        r1_rsp_ready = 1'b0;
        check({tag, "_drop"}, rsp_v(id), 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        r0_valid = 0; r0_opcode = 0; r0_a = 0; r0_b = 0; r0_c = 0; r0_d = 0;
        r1_valid = 0; r1_opcode = 0; r1_a = 0; r1_b = 0; r1_c = 0; r1_d = 0;
        r0_rsp_ready = 0; r1_rsp_ready = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_v0", r0_rsp_valid, 1'b0);
        check("rst_v1", r1_rsp_valid, 1'b0);
        check("rst_calc_a", calc_a, 16'd0);
        check("rst_data", rsp_data, 16'd0);
        check("rst_err", rsp_err, 1'b0);
        check("rst_rdy0", r0_ready, 1'b0);

        // Single op: r0 add 2+2
        drive(0, 8'd0, 16'd2, 16'd2);
        #1;
        check("single_rdy0", r0_ready, 1'b1);
        check("single_rdy1", r1_ready, 1'b0);
        tick();
        r0_valid = 1'b0;
        check("single_rdy0_off", r0_ready, 1'b0);
        check("single_busy", busy, 1'b1);
        check("single_calc_a", calc_a, 16'd2);
        check("single_calc_b", calc_b, 16'd2);
        wait_rsp("single", 0, 2, 16'd4, 1'b0);
        take_rsp("single", 0);

        // Backpressure: r1 div 10/2, response held for 5 cycles while r0 waits
        drive(1, 8'd3, 16'd10, 16'd2);
        #1;
        check("bp_rdy1", r1_ready, 1'b1);
        tick();
        r1_valid = 1'b0;
        wait_rsp("bp", 1, 2, 16'd5, 1'b0);
        drive(0, 8'd0, 16'd1, 16'd1);
        r0_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_v", r1_rsp_valid, 1'b1);
            check("bp_hold_data", rsp_data, 16'd5);
            check("bp_rdy0", r0_ready, 1'b0);
            check("bp_busy", busy, 1'b1);
        end
        r0_valid = 1'b0;
        r0_rsp_ready = 1'b0;
        take_rsp("bp", 1);

        // Contention: last grant was r1, so r0 wins the tie
        drive(0, 8'd1, 16'd10, 16'd2);
        drive(1, 8'd2, 16'd5, 16'd5);
        #1;
        check("tie1_rdy0", r0_ready, 1'b1);
        check("tie1_rdy1", r1_ready, 1'b0);
        tick();
        r0_valid = 1'b0;
        check("tie1_rdy1_wait", r1_ready, 1'b0);
        wait_rsp("tie1_r0", 0, 2, 16'd8, 1'b0);
        take_rsp("tie1_r0", 0);
        #1;
        check("tie1_rdy1_now", r1_ready, 1'b1);
        tick();
        r1_valid = 1'b0;
        wait_rsp("tie1_r1", 1, 2, 16'd25, 1'b0);
        take_rsp("tie1_r1", 1);

        // Illegal opcode from r0: immediate error response, calculator inputs untouched
        drive(0, 8'd7, 16'd99, 16'd99);
        #1;
        check("ill_rdy0", r0_ready, 1'b1);
        tick();
        r0_valid = 1'b0;
        wait_rsp("ill", 0, 0, 16'd0, 1'b1);
        check("ill_calc_a", calc_a, 16'd5);
        check("ill_calc_op", calc_opcode, 8'd2);
        take_rsp("ill", 0);

        // Second tie: last grant was r0, so r1 goes first; r1 ready raised early
        drive(0, 8'd3, 16'd10, 16'd2);
        drive(1, 8'd0, 16'd1, 16'd1);
        r1_rsp_ready = 1'b1;
        #1;
        check("tie2_rdy1", r1_ready, 1'b1);
        check("tie2_rdy0", r0_ready, 1'b0);
        tick();
        r1_valid = 1'b0;
        wait_rsp("tie2_r1", 1, 2, 16'd2, 1'b0);
        take_rsp("tie2_r1", 1);
        #1;
        check("tie2_rdy0_now", r0_ready, 1'b1);
        tick();
        r0_valid = 1'b0;
        wait_rsp("tie2_r0", 0, 2, 16'd5, 1'b0);
        take_rsp("tie2_r0", 0);

`ifdef CALC_ARB_STATS_EN
        check("stats_g0", grant_cnt0, 16'd4);
        check("stats_g1", grant_cnt1, 16'd3);
        check("stats_err", err_cnt, 8'd1);
`endif

        // Reset mid-WAIT: r1 command abandoned, arbitration restarts with r0 preferred
        drive(1, 8'd0, 16'd3, 16'd4);
        #1;
        check("mid_rdy1", r1_ready, 1'b1);
        tick();
        r1_valid = 1'b0;
        r1_rsp_ready = 1'b1;
        check("mid_busy", busy, 1'b1);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_calc_a", calc_a, 16'd0);
        check("mid_rst_calc_op", calc_opcode, 8'd0);
        check("mid_rst_data", rsp_data, 16'd0);
`ifdef CALC_ARB_STATS_EN
        check("mid_rst_g0", grant_cnt0, 16'd0);
        check("mid_rst_g1", grant_cnt1, 16'd0);
        check("mid_rst_err", err_cnt, 8'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            check("mid_no_rsp", r1_rsp_valid, 1'b0);
            tick();
        end
        r1_rsp_ready = 1'b0;

        drive(0, 8'd0, 16'd7, 16'd8);
        drive(1, 8'd1, 16'd9, 16'd1);
        #1;
        check("post_rst_rdy0", r0_ready, 1'b1);
        check("post_rst_rdy1", r1_ready, 1'b0);
        tick();
        r0_valid = 1'b0;
        wait_rsp("post_r0", 0, 2, 16'd15, 1'b0);
        take_rsp("post_r0", 0);
        #1;
        check("post_rdy1", r1_ready, 1'b1);
        tick();
        r1_valid = 1'b0;
        wait_rsp("post_r1", 1, 2, 16'd8, 1'b0);
        take_rsp("post_r1", 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
